// File: rtl/gemm_pkg.sv
// Shared GEMM front-end types: the uCode command header layout and the
// state encoding of the command parser.
package gemm_pkg;

    localparam int cmd_buf_width_gp   = 32;
    localparam int cmd_max_payload_gp = 4;
    localparam int cmd_len_width_gp   = 3;

    typedef struct packed {
        logic [7:0]                  opcode;
        logic [7:0]                  id;
        logic [4:0]                  rsvd_hi;
        logic [cmd_len_width_gp-1:0] len;
        logic [7:0]                  rsvd_lo;
    } cmd_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAY     = 3'd2,
        ST_DISCARD = 3'd3,
        ST_EMIT    = 3'd4
    } cmd_parser_state_e;

endpackage

// File: rtl/cmd_parser.sv
// Drains the command FIFO, assembles header + payload words into one parallel
// bundle for the GEMM dispatcher, and drops over-length commands.
module cmd_parser
    import gemm_pkg::*;
#(
    parameter int CMD_WIDTH   = cmd_buf_width_gp,
    parameter int MAX_PAYLOAD = cmd_max_payload_gp,
    parameter int LEN_W       = cmd_len_width_gp
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [CMD_WIDTH-1:0]             i_fifo_rd_data,
    input  logic                             i_fifo_empty,
    output logic                             o_fifo_rd_en,
    output logic                             o_cmd_valid,
    input  logic                             i_cmd_ready,
    output logic [7:0]                       o_cmd_opcode,
    output logic [7:0]                       o_cmd_id,
    output logic [LEN_W-1:0]                 o_cmd_len,
    output logic [MAX_PAYLOAD*CMD_WIDTH-1:0] o_cmd_payload,
    output logic                             o_err_len,
    output logic [7:0]                       o_err_count,
    output logic [15:0]                      o_cmd_count,
    output logic                             o_busy
);

    localparam int               PAY_W   = MAX_PAYLOAD * CMD_WIDTH;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    cmd_parser_state_e state_q, state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        id_q, id_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  req_left_q, req_left_d;
    logic [LEN_W-1:0]  rcv_left_q, rcv_left_d;
    logic [PAY_W-1:0]  payload_q, payload_d;
    logic              err_len_q, err_len_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [15:0]       cmd_count_q, cmd_count_d;

    logic              rd_req;
    cmd_hdr_t          hdr;
    logic [LEN_W-1:0]  hdr_len;
    logic [LEN_W-1:0]  wr_idx;
    logic              unused_hdr_bits;

    assign hdr             = cmd_hdr_t'(i_fifo_rd_data[31:0]);
    assign hdr_len         = LEN_W'(hdr.len);
    assign unused_hdr_bits = ^{hdr.rsvd_hi, hdr.rsvd_lo};
    assign wr_idx          = len_q - rcv_left_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        opcode_d    = opcode_q;
        id_d        = id_q;
        len_d       = len_q;
        req_left_d  = req_left_q;
        rcv_left_d  = rcv_left_q;
        payload_d   = payload_q;
        err_len_d   = err_len_q;
        err_count_d = err_count_q;
        cmd_count_d = cmd_count_q;
        rd_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rd_req = ~i_fifo_empty;
                if (rd_req) state_d = ST_HDR;
            end

            ST_HDR: begin
                opcode_d   = hdr.opcode;
                id_d       = hdr.id;
                len_d      = hdr_len;
                payload_d  = '0;
                rcv_left_d = hdr_len;
                // The first payload read overlaps the header decode to save a cycle.
                rd_req     = (hdr_len != '0) & ~i_fifo_empty;
                req_left_d = rd_req ? hdr_len - ONE : hdr_len;
                if (hdr_len == '0) begin
                    state_d = ST_EMIT;
                end else if (hdr_len > MAX_LEN) begin
                    err_len_d   = 1'b1;
                    err_count_d = (err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
                    state_d     = ST_DISCARD;
                end else begin
                    state_d = ST_PAY;
                end
            end

            ST_PAY, ST_DISCARD: begin
                rd_req = (req_left_q != '0) & ~i_fifo_empty;
                if (rd_req) req_left_d = req_left_q - ONE;
                if (rd_valid_q) begin
                    if (state_q == ST_PAY) begin
                        for (int k = 0; k < MAX_PAYLOAD; k++) begin
                            if (wr_idx == LEN_W'(k)) payload_d[k*CMD_WIDTH +: CMD_WIDTH] = i_fifo_rd_data;
                        end
                    end
                    rcv_left_d = rcv_left_q - ONE;
                    if (rcv_left_q == ONE) state_d = (state_q == ST_PAY) ? ST_EMIT : ST_IDLE;
                end
            end

            ST_EMIT: begin
                if (i_cmd_ready) begin
                    cmd_count_d = cmd_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            rd_valid_q  <= 1'b0;
            opcode_q    <= '0;
            id_q        <= '0;
            len_q       <= '0;
            req_left_q  <= '0;
            rcv_left_q  <= '0;
            // NOTE: the payload register is reset because unused words must read as zero from the start.
            payload_q   <= '0;
            err_len_q   <= 1'b0;
            err_count_q <= '0;
            cmd_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
            state_q     <= state_d;
            rd_valid_q  <= rd_req;
            opcode_q    <= opcode_d;
            id_q        <= id_d;
            len_q       <= len_d;
            req_left_q  <= req_left_d;
            rcv_left_q  <= rcv_left_d;
            payload_q   <= payload_d;
            err_len_q   <= err_len_d;
            err_count_q <= err_count_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    // Gating with reset keeps every output low for the whole reset pulse.
    assign o_fifo_rd_en  = rd_req & ~i_reset;
    assign o_cmd_valid   = (state_q == ST_EMIT);
    assign o_cmd_opcode  = opcode_q;
    assign o_cmd_id      = id_q;
    assign o_cmd_len     = len_q;
    assign o_cmd_payload = payload_q;
    assign o_err_len     = err_len_q;
    assign o_err_count   = err_count_q;
    assign o_cmd_count   = cmd_count_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: a behavioural FIFO feeds commands, expected
// bundles are queued at push time and compared when o_cmd_valid rises.
`timescale 1ns/1ps
module tb_cmd_parser;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  fifo_rd_data = '0;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic         cmd_valid;
    logic         cmd_ready = 1'b1;
    logic [7:0]   cmd_opcode;
    logic [7:0]   cmd_id;
    logic [2:0]   cmd_len;
    logic [127:0] cmd_payload;
    logic         err_len;
    logic [7:0]   err_count;
    logic [15:0]  cmd_count;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_parser dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_fifo_rd_data (fifo_rd_data),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (fifo_rd_en),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (cmd_ready),
        .o_cmd_opcode   (cmd_opcode),
        .o_cmd_id       (cmd_id),
        .o_cmd_len      (cmd_len),
        .o_cmd_payload  (cmd_payload),
        .o_err_len      (err_len),
        .o_err_count    (err_count),
        .o_cmd_count    (cmd_count),
        .o_busy         (busy)
    );

    // Behavioural FIFO: data appears the cycle after an accepted read.
    logic [31:0] fifo_mem [256];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    logic        fifo_flush = 1'b0;
    int          rd_count = 0;
    int          rd_while_empty = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
            rd_count     <= rd_count + 1;
        end
        if (fifo_rd_en && fifo_empty) rd_while_empty <= rd_while_empty + 1;
    end

    typedef struct {
        logic [7:0]   opcode;
        logic [7:0]   id;
        logic [2:0]   len;
        logic [127:0] payload;
    } exp_t;

    exp_t sb[$];

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic expect_cmd(input logic [7:0] op, input logic [7:0] id,
                              input logic [2:0] len, input logic [127:0] pay);
        exp_t e;
        e.opcode = op; e.id = id; e.len = len; e.payload = pay;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string name, output int cyc);
        cyc = 0;
        while (cmd_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cmd_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_timeout: o_cmd_valid=%b after %0d cycles, required 1", name, cmd_valid, cyc);
            cyc = -1;
        end
    endtask

    task automatic check_bundle(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: bundle opcode=%h seen, required none", name, cmd_opcode);
        end else begin
            e = sb.pop_front();
            checks++;
            if (cmd_opcode !== e.opcode) begin
                errors++; $display("FAIL %s_opcode: got %h required %h", name, cmd_opcode, e.opcode);
            end
            checks++;
            if (cmd_id !== e.id) begin
                errors++; $display("FAIL %s_id: got %h required %h", name, cmd_id, e.id);
            end
            checks++;
            if (cmd_len !== e.len) begin
                errors++; $display("FAIL %s_len: got %0d required %0d", name, cmd_len, e.len);
            end
            checks++;
            if (cmd_payload !== e.payload) begin
                errors++; $display("FAIL %s_payload: got %h required %h", name, cmd_payload, e.payload);
            end
        end
    endtask

    task automatic check_count(input string name, input logic [15:0] exp);
        checks++;
        if (cmd_count !== exp) begin
            errors++; $display("FAIL %s_cmd_count: got %0d required %0d", name, cmd_count, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_valid, busy, fifo_rd_en, err_len, err_count, cmd_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b rd_en=%b err=%b errcnt=%0d cnt=%0d, required all 0",
                     cmd_valid, busy, fifo_rd_en, err_len, err_count, cmd_count);
        end
        checks++;
        if ({cmd_opcode, cmd_id, cmd_len, cmd_payload} !== '0) begin
            errors++; $display("FAIL reset_bundle: got %h %h %0d %h, required 0", cmd_opcode, cmd_id, cmd_len, cmd_payload);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_len0();
        int cyc;
        push_word(32'h01050000);
        expect_cmd(8'h01, 8'h05, 3'd0, '0);
        wait_valid("len0", cyc);
        checks++;
        if (cyc != 2) begin
            errors++; $display("FAIL len0_latency: got %0d cycles required 2", cyc);
        end
        check_bundle("len0");
        @(negedge clk);
        check_count("len0", 16'd1);
    endtask

    task automatic test_len2();
        int cyc;
        int rd0;
        logic [7:0] mask;
        rd0 = rd_count;
        mask = '0;
        push_word(32'h10200200);
        push_word(32'hAAAA0001);
        push_word(32'hBBBB0002);
        expect_cmd(8'h10, 8'h20, 3'd2, {64'h0, 32'hBBBB0002, 32'hAAAA0001});
        #1 mask[0] = fifo_rd_en;
        cyc = 0;
        while (cmd_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cyc < 8) mask[cyc] = fifo_rd_en;
        end
        checks++;
        if (cyc != 4) begin
            errors++; $display("FAIL len2_latency: got %0d cycles required 4", cyc);
        end
        checks++;
        if (mask[4:0] !== 5'b00111) begin
            errors++; $display("FAIL len2_read_cycles: got %b required 00111", mask[4:0]);
        end
        checks++;
        if (rd_count - rd0 != 3) begin
            errors++; $display("FAIL len2_read_count: got %0d required 3", rd_count - rd0);
        end
        check_bundle("len2");
        @(negedge clk);
        check_count("len2", 16'd2);
    endtask

    task automatic test_discard();
        int cyc;
        push_word(32'h30000700);
        for (int i = 0; i < 7; i++) push_word(32'hD0000000 + i);
        push_word(32'h02000000);
        expect_cmd(8'h02, 8'h00, 3'd0, '0);
        wait_valid("discard", cyc);
        check_bundle("discard");
        checks++;
        if (err_len !== 1'b1 || err_count !== 8'd1) begin
            errors++; $display("FAIL discard_err: err_len=%b err_count=%0d required 1/1", err_len, err_count);
        end
        checks++;
        if (rd_ptr !== wr_ptr) begin
            errors++; $display("FAIL discard_drain: rd_ptr=%0d required %0d", rd_ptr, wr_ptr);
        end
        @(negedge clk);
        check_count("discard", 16'd3);
        repeat (5) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL discard_extra_bundle: o_cmd_valid=%b required 0", cmd_valid);
        end
    endtask

    task automatic test_trickle();
        int cyc;
        logic [127:0] pay;
        push_word(32'h40110400);
        for (int i = 0; i < 4; i++) pay[i*32 +: 32] = 32'hC0DE0000 + i;
        expect_cmd(8'h40, 8'h11, 3'd4, pay);
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL trickle_wait%0d: valid=%b busy=%b required 0/1", i, cmd_valid, busy);
            end
            push_word(32'hC0DE0000 + i);
        end
        wait_valid("trickle", cyc);
        check_bundle("trickle");
        checks++;
        if (rd_while_empty != 0) begin
            errors++; $display("FAIL trickle_rd_empty: got %0d reads while empty required 0", rd_while_empty);
        end
        @(negedge clk);
        check_count("trickle", 16'd4);
    endtask

    task automatic test_back_pressure();
        int cyc;
        logic [146:0] snap;
        logic [7:0]   snap_ptr;
        cmd_ready = 1'b0;
        push_word(32'h05010100);
        push_word(32'h11111111);
        push_word(32'h06020100);
        push_word(32'h22222222);
        expect_cmd(8'h05, 8'h01, 3'd1, {96'h0, 32'h11111111});
        expect_cmd(8'h06, 8'h02, 3'd1, {96'h0, 32'h22222222});
        wait_valid("bp_first", cyc);
        snap     = {cmd_opcode, cmd_id, cmd_len, cmd_payload};
        snap_ptr = rd_ptr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || fifo_rd_en !== 1'b0 || rd_ptr !== snap_ptr ||
                {cmd_opcode, cmd_id, cmd_len, cmd_payload} !== snap) begin
                errors++;
                $display("FAIL bp_stall%0d: valid=%b rd_en=%b rd_ptr=%0d, required 1/0/%0d with stable bundle",
                         i, cmd_valid, fifo_rd_en, rd_ptr, snap_ptr);
            end
        end
        check_bundle("bp_first");
        cmd_ready = 1'b1;
        @(negedge clk);
        wait_valid("bp_second", cyc);
        check_bundle("bp_second");
        @(negedge clk);
        check_count("bp", 16'd6);
    endtask

    task automatic test_reset_mid();
        int cyc;
        push_word(32'h07000400);
        push_word(32'h000000E1);
        push_word(32'h000000E2);
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: busy=%b valid=%b required 1/0", busy, cmd_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, busy, fifo_rd_en, err_len, err_count, cmd_count,
             cmd_opcode, cmd_id, cmd_len, cmd_payload} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: valid=%b busy=%b rd_en=%b err=%b cnt=%0d op=%h pay=%h, required all 0",
                     cmd_valid, busy, fifo_rd_en, err_len, cmd_count, cmd_opcode, cmd_payload);
        end
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        push_word(32'h04000000);
        expect_cmd(8'h04, 8'h00, 3'd0, '0);
        wait_valid("rstmid", cyc);
        checks++;
        if (cyc != 2) begin
            errors++; $display("FAIL rstmid_latency: got %0d cycles required 2", cyc);
        end
        check_bundle("rstmid");
        @(negedge clk);
        check_count("rstmid", 16'd1);
    endtask

    initial begin
        #1;
        test_reset();
        test_len0();
        test_len2();
        test_discard();
        test_trickle();
        test_back_pressure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d bundles never seen, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Sits directly downstream of the command FIFO and drains it word by word.
- Assembles each variable-length uCode command: one header word followed by 0..N payload words.
- Presents each command as one parallel bundle on a valid/ready interface to the GEMM command dispatcher.
- Detects over-length commands, discards their payload so the stream stays aligned, and keeps debug counters.

Parameters:
- CMD_WIDTH, 32, width of one FIFO word (equals cmd_buf_width_gp).
- MAX_PAYLOAD, 4, maximum payload words held per command (1..7).
- LEN_W, 3, width of the header length field, in bits.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_fifo_rd_data  in  CMD_WIDTH  FIFO read data; valid one cycle after an accepted o_fifo_rd_en.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd_en  out  1  FIFO read request.
- o_cmd_valid  out  1  command bundle valid.
- i_cmd_ready  in  1  downstream accepts the bundle.
- o_cmd_opcode  out  8  header bits [31:24].
- o_cmd_id  out  8  header bits [23:16].
- o_cmd_len  out  LEN_W  number of payload words carried.
- o_cmd_payload  out  MAX_PAYLOAD*CMD_WIDTH  payload word k at bits [k*32 +: 32]; unused words are zero.
- o_err_len  out  1  sticky over-length error flag.
- o_err_count  out  8  over-length command count, saturating.
- o_cmd_count  out  16  commands delivered, wrapping.
- o_busy  out  1  high in every state except ST_IDLE.

Behaviour:
- Header format: [31:24] opcode, [23:16] id, [10:8] len, all other bits reserved and ignored.
- Reset (async, immediate): state ST_IDLE, all outputs 0, counters 0, payload register 0.
  - A FIFO read issued before reset is dropped; its data is never captured.
- Read acceptance: a read is accepted when o_fifo_rd_en=1 and i_fifo_empty=0.
  - o_fifo_rd_en is never asserted while i_fifo_empty=1.
  - The accepted word is sampled on the following cycle, through a registered rd_valid_q.
- State machine:
  - ST_IDLE: o_fifo_rd_en = ~i_fifo_empty; on acceptance go to ST_HDR.
  - ST_HDR (header word present):
    - Latch opcode, id and len; clear the payload register.
    - If len==0: go to ST_EMIT.
    - If len > MAX_PAYLOAD: set o_err_len, increment o_err_count, go to ST_DISCARD with rcv_left=len.
    - Otherwise go to ST_PAY with rcv_left=len.
    - In this same cycle, o_fifo_rd_en = (len!=0) & ~i_fifo_empty, decoded combinationally from i_fifo_rd_data.
  - ST_PAY:
    - Issue back-to-back reads while req_left>0 and the FIFO is not empty.
    - Each rd_valid_q stores the word at index (len - rcv_left) and decrements rcv_left.
    - The capture that brings rcv_left to 0 moves to ST_EMIT.
  - ST_DISCARD: same read and count sequence as ST_PAY, but words are dropped; on the last word go to ST_IDLE. No bundle is emitted.
  - ST_EMIT:
    - o_cmd_valid=1; the bundle stays stable until i_cmd_ready.
    - On handshake: increment o_cmd_count, go to ST_IDLE.
    - o_fifo_rd_en=0 throughout this state.
- Counters: req_left and rcv_left are each LEN_W bits; req_left never exceeds rcv_left.
- Latency: len=2 with the FIFO holding 3 words, read starting at cycle 0 → o_cmd_valid asserted at cycle 4 (reads at cycles 0, 1, 2).
- FIFO empty mid-command: stall in ST_PAY or ST_DISCARD with no timeout; resume on the first cycle the FIFO is non-empty.
- Back-pressure: while i_cmd_ready=0 the FIFO is not read, so the upstream FIFO absorbs the stall.
- o_err_count saturates at 255. o_cmd_count wraps at 16 bits.
- o_err_len clears only on reset.

Decomposition:
- gemm_pkg additions:
  - cmd_hdr_t packed struct: opcode, id, rsvd, len, rsvd.
  - cmd_max_payload_gp = 4.
  - cmd_len_width_gp = 3.
  - cmd_parser_state_e enum: ST_IDLE, ST_HDR, ST_PAY, ST_DISCARD, ST_EMIT.
- Single module, no sub-module. The read-request/receive counter logic is shared by ST_PAY and ST_DISCARD.

Test Plan:
- FIFO holds 0x01050000 (len 0) → o_cmd_valid at cycle 2, opcode 0x01, id 0x05, len 0, payload all zero; o_cmd_count=1.
- Header 0x10200200 plus payload 0xAAAA0001, 0xBBBB0002, with i_cmd_ready=1 → reads at cycles 0, 1, 2; valid at cycle 4; payload[31:0]=0xAAAA0001, payload[63:32]=0xBBBB0002.
- Header len 7 (0x30000700) + 7 words, then header 0x02000000 → 7 words discarded, o_err_len=1, o_err_count=1; only the opcode 0x02 bundle is emitted.
- len=4 command whose payload words arrive one every 3 cycles → o_fifo_rd_en is never high while empty; the bundle is correct after the last word.
- Two queued len=1 commands with i_cmd_ready held low for 10 cycles → the first bundle stays stable, no FIFO reads occur, and the second command emits after the handshake.
- Assert i_reset during ST_PAY (2 of 4 words captured) → all outputs 0 immediately; after release, a fresh header 0x04000000 parses correctly.
